// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C register-read master among N_REQ requesters.
// Optional watchdog on the master's done pulse: define I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_start,
  input  logic [7*N_REQ-1:0]   req_dev_addr,
  input  logic [8*N_REQ-1:0]   req_reg_addr,
  output logic [N_REQ-1:0]     req_busy,
  output logic [N_REQ-1:0]     rsp_done,
  output logic [15:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 m_start,
  output logic [6:0]           m_dev_addr,
  output logic [7:0]           m_reg_addr,
  input  logic [15:0]          m_data_in,
  input  logic                 m_done,
  input  logic                 m_busy
);

  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] OneHot0 = N_REQ'(1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StRelease} state_e;

  state_e           r_state, w_state_d;
  logic [N_REQ-1:0] r_pending, w_pending_d, w_accept, w_busy_d, w_clr;
  logic [GW-1:0]    r_grant, r_last_grant, w_grant_d, w_pick, w_idx;
  logic             w_found, w_grant_now, w_timeout;
  logic [6:0]       r_dev [N_REQ];
  logic [7:0]       r_reg [N_REQ];

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    w_pick  = r_last_grant;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_idx = GW'((32'(r_last_grant) + k) % N_REQ);
      if (!w_found && r_pending[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_grant_now = (r_state == StIdle) && (|r_pending) && !m_busy;
  assign w_grant_d   = w_grant_now ? w_pick : r_grant;
  assign w_clr       = w_grant_now ? (OneHot0 << w_pick) : '0;
  assign w_pending_d = (r_pending | w_accept) & ~w_clr;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign w_accept[gi] = req_start[gi] && !r_pending[gi] &&
                          !((r_state != StIdle) && (r_grant == GW'(gi)));
    assign w_busy_d[gi] = w_pending_d[gi] ||
                          ((w_state_d != StIdle) && (w_grant_d == GW'(gi)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:     if (w_grant_now) w_state_d = StIssue;
      StIssue:    w_state_d = StWaitDone;
      StWaitDone: begin
        if (m_done)         w_state_d = StRelease;
        else if (w_timeout) w_state_d = StIdle;
      end
      StRelease:  if (!m_busy) w_state_d = StIdle;
      default:    w_state_d = StIdle;
    endcase
  end

  always_comb begin
    m_start = 1'b0;
    if (r_state == StIssue) m_start = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending    <= '0;
      r_grant      <= '0;
      r_last_grant <= GW'(N_REQ - 1);
      req_busy     <= '0;
      rsp_done     <= '0;
      rsp_data     <= '0;
      m_dev_addr   <= '0;
      m_reg_addr   <= '0;
    end else begin
      r_pending <= w_pending_d;
      req_busy  <= w_busy_d;
      rsp_done  <= '0;
      if (w_grant_now) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
        m_dev_addr   <= r_dev[w_pick];
        m_reg_addr   <= r_reg[w_pick];
      end
      if ((r_state == StWaitDone) && m_done) begin
        rsp_done <= OneHot0 << r_grant;
        rsp_data <= m_data_in;
      end else if (w_timeout) begin
        rsp_done <= OneHot0 << r_grant;
        rsp_data <= 16'hFFFF;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        r_dev[i] <= '0;
        r_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_accept[i]) begin
          r_dev[i] <= req_dev_addr[7*i +: 7];
          r_reg[i] <= req_reg_addr[8*i +: 8];
        end
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0] r_cnt;
  logic        r_rsp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_cnt <= '0;
    else if (r_state == StIssue)      r_cnt <= '0;
    else if (r_state == StWaitDone)   r_cnt <= r_cnt + 32'd1;
  end

  // Fires on the cycle the count would reach the limit; m_done takes priority.
  assign w_timeout = (r_state == StWaitDone) && !m_done &&
                     (r_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rsp_err <= 1'b0;
    else     r_rsp_err <= w_timeout;
  end

  assign rsp_err = r_rsp_err;
`else
  // Watchdog compiled out; WAIT_DONE waits for m_done indefinitely.
  assign w_timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter with a behavioural I2C master model.
module tb_i2c_bus_arbiter;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_start;
  logic [13:0] req_dev_addr;
  logic [15:0] req_reg_addr;
  logic [1:0]  req_busy, rsp_done;
  logic [15:0] rsp_data, m_data_in;
  logic        rsp_err, m_start, m_done, m_busy;
  logic [6:0]  m_dev_addr;
  logic [7:0]  m_reg_addr;

  i2c_bus_arbiter #(.N_REQ(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_start(req_start), .req_dev_addr(req_dev_addr),
    .req_reg_addr(req_reg_addr), .req_busy(req_busy), .rsp_done(rsp_done),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .m_start(m_start), .m_dev_addr(m_dev_addr),
    .m_reg_addr(m_reg_addr), .m_data_in(m_data_in), .m_done(m_done), .m_busy(m_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [6:0] dev; logic [7:0] ra; int scyc; } st_t;
  typedef struct { logic [1:0] done; logic [15:0] data; logic err; } rs_t;

  st_t         st_q[$];
  rs_t         rs_q[$];
  logic [15:0] data_q[$];

  int tests = 0, fails = 0;
  int rsp_seen = 0, last_start_cyc = 0;
  int mdl_lat = 3, mdl_tail = 2, mdl_kick = 0;
  bit mdl_hang = 1'b0, mdl_send = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic expect_txn(input int idx, input logic [6:0] dev, input logic [7:0] ra,
                            input logic [15:0] data, input int scyc);
    st_q.push_back('{dev, ra, scyc});
    rs_q.push_back('{2'(1 << idx), data, 1'b0});
    data_q.push_back(data);
  endtask

  task automatic pulse(input logic [1:0] mask, input logic [6:0] d0, input logic [7:0] r0,
                       input logic [6:0] d1, input logic [7:0] r1, output int c);
    @(negedge clk);
    c            = cyc;
    req_dev_addr = {d1, d0};
    req_reg_addr = {r1, r0};
    req_start    = mask;
    @(negedge clk);
    req_start    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      busy = (st_q.size() != 0) || (rs_q.size() != 0) || m_busy || (req_busy != 0);
    end
    tests++;
    if (busy) begin
      fails++;
      $display("FAIL %s_drain: still busy after %0d cycles (st=%0d rs=%0d), required idle",
               name, n, st_q.size(), rs_q.size());
    end
  endtask

  task automatic wait_busy(input string name, input logic level);
    int n;
    n = 0;
    while (m_busy !== level && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_mbusy"}, 64'(m_busy), 64'(level));
  endtask

  // Master model: raises busy on m_start, then returns data with a one-cycle done.
  initial begin
    bit hang, send;
    int seen;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_data_in = '0;
    forever begin
      @(negedge clk);
      if (m_start) begin
        hang = mdl_hang;
        send = mdl_send;
        seen = mdl_kick;
        m_busy = 1'b1;
        if (hang) while (mdl_kick == seen) @(negedge clk);
        else repeat (mdl_lat) @(negedge clk);
        if (send) begin
          m_data_in = (data_q.size() != 0) ? data_q.pop_front() : 16'h0000;
          m_done = 1'b1;
          @(negedge clk);
          m_done = 1'b0;
        end
        repeat (mdl_tail) @(negedge clk);
        m_busy = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents m_start or rsp_done.
  initial begin
    st_t e;
    rs_t r;
    forever begin
      @(posedge clk);
      #1;
      if (m_start) begin
        check("start_while_busy", 64'(m_busy), 64'(0));
        last_start_cyc = cyc;
        if (st_q.size() == 0) begin
          check("unexpected_m_start", 64'(1), 64'(0));
        end else begin
          e = st_q.pop_front();
          check("m_addr", {m_dev_addr, m_reg_addr}, {e.dev, e.ra});
          if (e.scyc >= 0) check("m_start_lat", 64'(cyc), 64'(e.scyc));
        end
      end
      if (rsp_done != 2'b00) begin
        rsp_seen++;
        if (rs_q.size() == 0) begin
          check("unexpected_rsp_done", {rsp_done, rsp_data}, 64'(0));
        end else begin
          r = rs_q.pop_front();
          check("rsp", {rsp_done, rsp_data, rsp_err}, {r.done, r.data, r.err});
          if (!r.err) check("rsp_lat", 64'(m_done), 64'(1));
          else        check("timeout_lat", 64'(cyc - last_start_cyc), 64'(TO + 1));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, rs0, n;
    int cnt[2];
    rst = 1'b1;
    req_start = '0;
    req_dev_addr = '0;
    req_reg_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_outputs",
          {req_busy, rsp_done, rsp_data, rsp_err, m_start, m_dev_addr, m_reg_addr}, 64'(0));

    // Single request on an idle bus.
    pulse(2'b01, 7'h29, 8'h96, 7'h00, 8'h00, c);
    expect_txn(0, 7'h29, 8'h96, 16'hBEEF, c + 2);
    check("busy_set", 64'(req_busy), 64'(2'b01));
    rs0 = rsp_seen;
    n = 0;
    while (rsp_seen == rs0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("single_rsp_seen", 64'(rsp_seen - rs0), 64'(1));
    wait_busy("single", 1'b0);
    check("busy_clear", 64'(req_busy), 64'(0));
    wait_drain("single", 100);
    repeat (3) @(posedge clk);
    #1;
    check("rsp_data_hold", 64'(rsp_data), 64'(16'hBEEF));

    // Simultaneous requests from reset: 0 then 1.
    do_reset();
    pulse(2'b11, 7'h29, 8'h96, 7'h52, 8'h9A, c);
    expect_txn(0, 7'h29, 8'h96, 16'h1111, c + 2);
    expect_txn(1, 7'h52, 8'h9A, 16'h2222, -1);
    wait_drain("simul", 200);

    // Duplicate request while pending keeps the first addresses.
    pulse(2'b01, 7'h29, 8'h96, 7'h00, 8'h00, c);
    expect_txn(0, 7'h29, 8'h96, 16'h3333, c + 2);
    pulse(2'b10, 7'h00, 8'h00, 7'h52, 8'h9A, c);
    expect_txn(1, 7'h52, 8'h9A, 16'h4444, -1);
    pulse(2'b10, 7'h00, 8'h00, 7'h52, 8'h98, c);
    wait_drain("dup", 200);

    // Round-robin: both requesters re-request as soon as they go idle.
    for (int k = 0; k < 6; k++)
      expect_txn(k % 2, 7'h10 + 7'(k % 2), 8'h40 + 8'(k), 16'hA000 + 16'(k), -1);
    cnt[0] = 0;
    cnt[1] = 0;
    n = 0;
    while ((cnt[0] < 3 || cnt[1] < 3) && n < 2000) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < 2; i++) begin
        if (!req_busy[i] && cnt[i] < 3) begin
          req_dev_addr[7*i +: 7] = 7'h10 + 7'(i);
          req_reg_addr[8*i +: 8] = 8'h40 + 8'(2 * cnt[i] + i);
          req_start[i] = 1'b1;
          cnt[i]++;
        end else begin
          req_start[i] = 1'b0;
        end
      end
    end
    @(negedge clk);
    req_start = '0;
    wait_drain("rr", 500);

    // Reset while waiting for the master's done.
    mdl_hang = 1'b1;
    mdl_send = 1'b1;
    data_q.push_back(16'h1234);
    pulse(2'b01, 7'h33, 8'h44, 7'h00, 8'h00, c);
    st_q.push_back('{7'h33, 8'h44, c + 2});
    wait_busy("rst_op", 1'b1);
    mdl_hang = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_async",
          {req_busy, rsp_done, rsp_data, rsp_err, m_start, m_dev_addr, m_reg_addr}, 64'(0));
    @(negedge clk);
    rst = 1'b0;
    rs0 = rsp_seen;
    mdl_kick++;
    repeat (12) @(negedge clk);
    check("rst_no_done", 64'(rsp_seen - rs0), 64'(0));
    data_q.delete();

`ifdef I2C_ARB_TIMEOUT_EN
    // Master never answers: watchdog completes with an error.
    mdl_hang = 1'b1;
    mdl_send = 1'b0;
    pulse(2'b01, 7'h29, 8'h96, 7'h00, 8'h00, c);
    st_q.push_back('{7'h29, 8'h96, c + 2});
    rs_q.push_back('{2'b01, 16'hFFFF, 1'b1});
    wait_busy("to", 1'b1);
    mdl_hang = 1'b0;
    mdl_send = 1'b1;
    pulse(2'b10, 7'h00, 8'h00, 7'h52, 8'h9A, c);
    expect_txn(1, 7'h52, 8'h9A, 16'h5A5A, -1);
    rs0 = rsp_seen;
    n = 0;
    while (rsp_seen == rs0 && n < TO + 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("to_rsp_seen", 64'(rsp_seen - rs0), 64'(1));
    repeat (10) @(posedge clk);
    #1;
    check("to_hold_grant", 64'(st_q.size()), 64'(1));
    mdl_kick++;
    wait_drain("to", 300);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", 64'(st_q.size() + rs_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares the single `i2c_master_read2bytes` instance between N register-read requesters, e.g. the color sensor controller and a second sensor/counter controller.
- Latches each requester's one-cycle start pulse and its addresses, then grants the bus round-robin.
- Drives the master's start/address inputs and routes the 16-bit result and a done pulse back to the granted requester.
- Sits between the sensor controllers and the I2C master inside the top level.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 1000000, watchdog limit in clk cycles (10 ms at 100 MHz); used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_start  in  N_REQ  one-cycle read request pulse per requester
- req_dev_addr  in  7*N_REQ  7-bit device address per requester; slice i = bits [7i+6:7i]
- req_reg_addr  in  8*N_REQ  register address per requester; slice i = bits [8i+7:8i]
- req_busy  out  N_REQ  requester i has a pending or in-flight transaction
- rsp_done  out  N_REQ  one-cycle completion pulse to requester i
- rsp_data  out  16  read result; valid in the cycle any rsp_done bit is high
- rsp_err  out  1  completion was a timeout; qualified by rsp_done
- m_start  out  1  start pulse to the I2C master
- m_dev_addr  out  7  device address to the master
- m_reg_addr  out  8  register address to the master
- m_data_in  in  16  master data_out
- m_done  in  1  master done
- m_busy  in  1  master busy

Behaviour:
- Reset values: all outputs 0; pending = 0; last_grant = N_REQ-1 (so requester 0 wins first); state = IDLE. Reset mid-transaction aborts immediately and m_start drops asynchronously. The master is not reset by this block.
- Request latch:
  - req_start[i] high while pending[i]=0 and i is not the active grant: set pending[i]; capture the addresses into per-requester registers.
  - req_start[i] while pending or active for i: ignored; the first addresses are kept.
- req_busy[i] = pending[i] OR (state != IDLE AND grant == i), registered.
- IDLE: if any pending bit is set and m_busy == 0, pick the first pending index searching from last_grant+1 with wrap-around. Set grant and last_grant, clear that pending bit, load m_dev_addr/m_reg_addr, go to ISSUE.
- ISSUE: m_start = 1 for exactly this one cycle; go to WAIT_DONE.
- WAIT_DONE: m_start = 0. On m_done, register rsp_data = m_data_in and rsp_done[grant] = 1 for one cycle (rsp_err = 0); go to RELEASE.
- RELEASE: wait for m_busy == 0, then go to IDLE.
- m_dev_addr/m_reg_addr hold their value from ISSUE through RELEASE.
- Latency, idle bus: req_start sampled at edge t, m_start high in cycle t+2. m_done at edge d, rsp_done and rsp_data in cycle d+1.
- A request that collides with a completion is latched normally. The earliest next m_start is 2 cycles after RELEASE sees m_busy low.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,N_REQ-1,0. No requester waits more than N_REQ-1 transactions.
- The rsp_data register holds its last value between completions.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on ISSUE and increments in WAIT_DONE.
  - On reaching TIMEOUT_CYCLES without m_done: rsp_done[grant] = 1, rsp_err = 1, rsp_data = 16'hFFFF for one cycle, then state goes to IDLE, bypassing RELEASE.
  - IDLE still requires m_busy low before the next grant.
- Not defined: no counter is synthesized, rsp_err is tied to 0, and WAIT_DONE waits indefinitely.

Test Plan:
- Single request: req_start[0] pulse with dev 0x29, reg 0x96 → m_start high 2 cycles later carrying 0x29/0x96; master model returns m_done with 0xBEEF → rsp_done = 2'b01 and rsp_data = 0xBEEF one cycle later; req_busy[0] clears once m_busy is low.
- Simultaneous: req_start = 2'b11 from reset → requester 0 served first, then requester 1 with its own addresses; rsp_done order is 01 then 10.
- Round-robin: both requesters hammered for 6 transactions → grant order 0,1,0,1,0,1 and no m_start while m_busy is high.
- Duplicate: a second req_start[1] with reg 0x98 while requester 1 is pending with reg 0x9A → exactly one transaction, reg 0x9A.
- Reset mid-op: assert rst in WAIT_DONE → all outputs 0 asynchronously; after release, m_done from the master generates no rsp_done.
- Timeout (macro defined, TIMEOUT_CYCLES = 50, m_done never asserted) → rsp_done on the granted bit, rsp_err = 1, rsp_data = 0xFFFF 51 cycles after m_start; the next pending request is granted once m_busy is low.
